// File: rtl/sd_pkg.sv
// Shared SD-card SPI definitions: command words, expected responses, FSM
// state encoding and command selector used by the init sequencer.
package sd_pkg;

  localparam int unsigned CMD_W    = 48;
  localparam int unsigned R1_W     = 8;
  localparam int unsigned R7_W     = 32;
  localparam int unsigned RESP_W   = R1_W + R7_W;
  localparam int unsigned GAP_CLKS = 8;

  localparam logic [CMD_W-1:0] CMD0_WORD   = 48'h40_0000_0000_95;
  localparam logic [CMD_W-1:0] CMD8_WORD   = 48'h48_0000_01AA_87;
  localparam logic [CMD_W-1:0] CMD55_WORD  = 48'h77_0000_0000_65;
  localparam logic [CMD_W-1:0] ACMD41_WORD = 48'h69_4000_0000_77;

  localparam logic [R1_W-1:0] R1_IDLE  = 8'h01;
  localparam logic [R1_W-1:0] R1_READY = 8'h00;
  localparam logic [11:0]     R7_ECHO  = 12'h1AA;

  typedef enum logic [3:0] {
    sIdle,
    sDummy,
    sSendCmd,
    sWaitResp,
    sRecv,
    sCheck,
    sGap,
    sDone,
    sError
  } state_e;

  typedef enum logic [1:0] {
    CMD_0,
    CMD_8,
    CMD_55,
    CMD_A41
  } cmd_e;

  // Map a command selector onto its 48-bit frame.
  function automatic logic [CMD_W-1:0] cmd_word(input cmd_e c);
    logic [CMD_W-1:0] w;
    case (c)
      CMD_0:   w = CMD0_WORD;
      CMD_8:   w = CMD8_WORD;
      CMD_55:  w = CMD55_WORD;
      default: w = ACMD41_WORD;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sd_cmd_shifter.sv
// 48-bit command shifter: load a frame, then shift it out MSB first.
// Ports:
//   i_s_clk, i_reset : clock, async active-high reset
//   i_load, i_cmd    : load a new frame (first bit visible the next cycle)
//   o_bit            : current serial bit
//   o_busy           : bits remain to be sent
//   o_last           : current bit is the final one of the frame
module sd_cmd_shifter
  import sd_pkg::*;
(
  input  logic             i_s_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CMD_W-1:0] i_cmd,
  output logic             o_bit,
  output logic             o_busy,
  output logic             o_last
);

  localparam int unsigned CNT_W = $clog2(CMD_W + 1);

  logic [CMD_W-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;

  // Load or shift one bit per clock while bits remain.
  always_ff @(posedge i_s_clk or posedge i_reset) begin
    if (i_reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shift <= i_cmd;
      r_cnt   <= CNT_W'(CMD_W);
    end else if (r_cnt != '0) begin
      r_shift <= {r_shift[CMD_W-2:0], 1'b0};
      r_cnt   <= r_cnt - CNT_W'(1);
    end
  end

  assign o_bit  = r_shift[CMD_W-1];
  assign o_busy = (r_cnt != '0);
  assign o_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/sd_init_sequencer.sv
// SD card SPI-mode initialisation: dummy clocks, CMD0, CMD8, then
// CMD55/ACMD41 until the card leaves idle; afterwards the bus is handed to
// the SD writer.
// Ports:
//   i_s_clk, i_reset : SPI bit clock, async active-high reset
//   i_start          : one-cycle request to (re)start initialisation
//   MISO             : card serial data
//   o_mosi, o_cs_n   : serial data / chip select to the card
//   i_writer_mosi    : writer data, forwarded once the card is ready
//   o_writer_start   : one-cycle pulse when the card becomes ready
//   o_busy, o_ready, o_error : sequencer status
module sd_init_sequencer
  import sd_pkg::*;
#(
  parameter int unsigned DUMMY_CLKS   = 80,
  parameter int unsigned RESP_TIMEOUT = 64,
  parameter int unsigned RETRY_MAX    = 255
) (
  input  logic i_s_clk,
  input  logic i_reset,
  input  logic i_start,
  input  logic MISO,
  output logic o_mosi,
  output logic o_cs_n,
  input  logic i_writer_mosi,
  output logic o_writer_start,
  output logic o_busy,
  output logic o_ready,
  output logic o_error
);

  localparam int unsigned DUMMY_W = $clog2(DUMMY_CLKS + 1);
  localparam int unsigned TMO_W   = $clog2(RESP_TIMEOUT + 1);
  localparam int unsigned GAP_W   = $clog2(GAP_CLKS + 1);
  localparam int unsigned BIT_W   = $clog2(RESP_W + 1);

  state_e             r_state;
  cmd_e               r_cmd;
  logic [DUMMY_W-1:0] r_dummy_cnt;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [RESP_W-1:0]  r_resp;
  logic [7:0]         r_retry;
  logic               r_writer_start;
  logic               r_busy;
  logic               r_ready;
  logic               r_error;

  logic               w_load;
  logic               w_shift_bit;
  logic               w_shift_busy;
  logic               w_shift_last;
  logic               w_dummy_last;
  logic               w_gap_last;
  logic [CMD_W-1:0]   w_cmd_word;
  logic [R1_W-1:0]    w_r1;
  logic               w_r7_ok;
  logic [BIT_W-1:0]   w_resp_last;
  logic               w_retry_out;
  logic               w_pass;
  logic               w_done;
  cmd_e               w_next_cmd;

  assign w_dummy_last = (r_dummy_cnt == DUMMY_W'(DUMMY_CLKS - 1));
  assign w_gap_last   = (r_gap_cnt == GAP_W'(GAP_CLKS - 1));
  // Frame is loaded on the edge that enters sSendCmd so bit 47 shows at once.
  assign w_load       = ((r_state == sDummy) && w_dummy_last) ||
                        ((r_state == sGap) && w_gap_last);
  assign w_cmd_word   = cmd_word(r_cmd);

  sd_cmd_shifter u_cmd_shifter (
    .i_s_clk (i_s_clk),
    .i_reset (i_reset),
    .i_load  (w_load),
    .i_cmd   (w_cmd_word),
    .o_bit   (w_shift_bit),
    .o_busy  (w_shift_busy),
    .o_last  (w_shift_last)
  );

  // CMD8 answers with R1 followed by R7; all others return R1 only.
  assign w_r1        = (r_cmd == CMD_8) ? r_resp[RESP_W-1 -: R1_W] : r_resp[R1_W-1:0];
  assign w_r7_ok     = (r_resp[11:0] == R7_ECHO);
  assign w_resp_last = (r_cmd == CMD_8) ? BIT_W'(RESP_W - 1) : BIT_W'(R1_W - 1);
  assign w_retry_out = (({1'b0, r_retry} + 9'd1) >= 9'(RETRY_MAX));

  // Response check and choice of the next command.
  always_comb begin
    w_pass     = 1'b0;
    w_done     = 1'b0;
    w_next_cmd = r_cmd;
    case (r_cmd)
      CMD_0: begin
        w_pass     = (w_r1 == R1_IDLE);
        w_next_cmd = CMD_8;
      end
      CMD_8: begin
        w_pass     = (w_r1 == R1_IDLE) && w_r7_ok;
        w_next_cmd = CMD_55;
      end
      CMD_55: begin
        w_pass     = (w_r1 == R1_IDLE) || (w_r1 == R1_READY);
        w_next_cmd = CMD_A41;
      end
      default: begin
        w_done     = (w_r1 == R1_READY);
        w_pass     = (w_r1 == R1_IDLE) && !w_retry_out;
        w_next_cmd = CMD_55;
      end
    endcase
  end

  // Sequencer FSM with registered status outputs.
  always_ff @(posedge i_s_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= sIdle;
      r_cmd          <= CMD_0;
      r_dummy_cnt    <= '0;
      r_tmo_cnt      <= '0;
      r_gap_cnt      <= '0;
      r_bit_cnt      <= '0;
      r_resp         <= '0;
      r_retry        <= '0;
      r_writer_start <= 1'b0;
      r_busy         <= 1'b0;
      r_ready        <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_writer_start <= 1'b0;
      case (r_state)
        sIdle, sError: begin
          if (i_start) begin
            r_state     <= sDummy;
            r_cmd       <= CMD_0;
            r_dummy_cnt <= '0;
            r_retry     <= '0;
            r_busy      <= 1'b1;
            r_error     <= 1'b0;
          end
        end
        sDummy: begin
          if (w_dummy_last) r_state <= sSendCmd;
          else              r_dummy_cnt <= r_dummy_cnt + DUMMY_W'(1);
        end
        sSendCmd: begin
          if (w_shift_last) begin
            r_state   <= sWaitResp;
            r_tmo_cnt <= '0;
          end
        end
        sWaitResp: begin
          // The start bit is kept as R1 bit 7.
          if (!MISO) begin
            r_state   <= sRecv;
            r_resp    <= {r_resp[RESP_W-2:0], MISO};
            r_bit_cnt <= BIT_W'(1);
          end else if (r_tmo_cnt == TMO_W'(RESP_TIMEOUT - 1)) begin
            r_state <= sError;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end
        sRecv: begin
          r_resp    <= {r_resp[RESP_W-2:0], MISO};
          r_bit_cnt <= r_bit_cnt + BIT_W'(1);
          if (r_bit_cnt == w_resp_last) r_state <= sCheck;
        end
        sCheck: begin
          if (w_done) begin
            r_state        <= sDone;
            r_busy         <= 1'b0;
            r_ready        <= 1'b1;
            r_writer_start <= 1'b1;
          end else if (w_pass) begin
            r_state   <= sGap;
            r_gap_cnt <= '0;
            r_cmd     <= w_next_cmd;
            if (r_cmd == CMD_A41) r_retry <= r_retry + 8'd1;
          end else begin
            r_state <= sError;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
          end
        end
        sGap: begin
          if (w_gap_last) r_state <= sSendCmd;
          else            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Line idles high; the writer owns the data line once initialised.
  assign o_mosi = (r_state == sDone) ? i_writer_mosi :
                  ((r_state == sSendCmd) && w_shift_busy) ? w_shift_bit : 1'b1;
  assign o_cs_n = !(r_state inside {sSendCmd, sWaitResp, sRecv, sCheck, sGap, sDone});

  assign o_writer_start = r_writer_start;
  assign o_busy         = r_busy;
  assign o_ready        = r_ready;
  assign o_error        = r_error;

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Bench for sd_init_sequencer: behavioural SD card on MISO plus directed
// scenarios and a vector table for the post-init bus hand-over.
module tb_sd_init_sequencer;

  localparam int unsigned DUMMY = 80;
  localparam int unsigned TMO   = 64;
  localparam int unsigned RETRY = 3;

  localparam logic [47:0] C0  = 48'h40_0000_0000_95;
  localparam logic [47:0] C8  = 48'h48_0000_01AA_87;
  localparam logic [47:0] C55 = 48'h77_0000_0000_65;
  localparam logic [47:0] C41 = 48'h69_4000_0000_77;

  logic clk = 1'b0;
  logic rst, start, miso, wmosi;
  logic o_mosi, o_cs_n, o_ws, o_busy, o_ready, o_error;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int n0, n8, n55, n41;
  int dummy_cyc, cs_low_cyc, ws_cnt, ws_cyc, err_cyc, c0_cyc, c41_cyc, zeros8;
  bit silent, cmd8_bad;
  int a41_busy;
  logic [47:0] shreg = '1;
  bit rq[$];

  typedef struct {
    logic wm;
    logic st;
    logic exp_mosi;
    logic exp_cs_n;
    logic exp_ready;
  } vec_t;
  vec_t tv[6];

  sd_init_sequencer #(
    .DUMMY_CLKS   (DUMMY),
    .RESP_TIMEOUT (TMO),
    .RETRY_MAX    (RETRY)
  ) dut (
    .i_s_clk        (clk),
    .i_reset        (rst),
    .i_start        (start),
    .MISO           (miso),
    .o_mosi         (o_mosi),
    .o_cs_n         (o_cs_n),
    .i_writer_mosi  (wmosi),
    .o_writer_start (o_ws),
    .o_busy         (o_busy),
    .o_ready        (o_ready),
    .o_error        (o_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Two idle-high bits, then the response MSB first.
  task automatic push_resp(input logic [39:0] r, input int n);
    rq.push_back(1'b1);
    rq.push_back(1'b1);
    for (int i = n - 1; i >= 0; i--) rq.push_back(r[i]);
  endtask

  // Card model and observers, evaluated mid-cycle.
  always @(negedge clk) begin
    if (rq.size() != 0) miso = rq.pop_front();
    else                miso = 1'b1;
    if (o_busy && o_cs_n)     dummy_cyc++;
    if (!o_cs_n && !o_ready)  cs_low_cyc++;
    if (o_ws) begin ws_cnt++; ws_cyc = cyc; end
    if (o_error && err_cyc < 0) err_cyc = cyc;
    if (o_cs_n || o_ready) begin
      shreg = '1;
    end else begin
      if (n8 != 0 && o_mosi == 1'b0) zeros8++;
      shreg = {shreg[46:0], o_mosi};
      if (shreg == C0) begin
        n0++; c0_cyc = cyc;
        if (!silent) push_resp(40'h01, 8);
      end else if (shreg == C8) begin
        n8++;
        if (!silent) push_resp(cmd8_bad ? {8'h01, 32'h0000_00AA} : {8'h01, 32'h0000_01AA}, 40);
      end else if (shreg == C55) begin
        n55++;
        if (!silent) push_resp(40'h01, 8);
      end else if (shreg == C41) begin
        n41++; c41_cyc = cyc;
        if (!silent) push_resp((n41 <= a41_busy) ? 40'h01 : 40'h00, 8);
      end
    end
  end

  task automatic start_run();
    @(negedge clk); #1;
    n0 = 0; n8 = 0; n55 = 0; n41 = 0;
    dummy_cyc = 0; cs_low_cyc = 0; ws_cnt = 0; ws_cyc = -1;
    err_cyc = -1; c0_cyc = -1; c41_cyc = -1; zeros8 = 0;
    rq.delete();
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(o_ready || o_error) && n < 5000) begin
      @(negedge clk); #1;
      n++;
    end
    if (!(o_ready || o_error)) begin
      total++; bad++;
      $display("FAIL %s: no ready/error within %0d cycles", tag, n);
    end
  endtask

  initial begin
    tv[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; miso = 1'b1; wmosi = 1'b1;
    silent = 1'b0; cmd8_bad = 1'b0; a41_busy = 1;
    repeat (3) @(negedge clk); #1;
    chk("reset mosi", o_mosi, 1);
    chk("reset cs_n", o_cs_n, 1);
    chk("reset wstart", o_ws, 0);
    chk("reset busy", o_busy, 0);
    chk("reset ready", o_ready, 0);
    chk("reset error", o_error, 0);
    rst = 1'b0;

    // Silent card: timeout after CMD0.
    silent = 1'b1;
    start_run();
    chk("tmo busy", o_busy, 1);
    wait_end("tmo");
    chk("tmo error", o_error, 1);
    chk("tmo ready", o_ready, 0);
    chk("tmo busy end", o_busy, 0);
    chk("tmo cs_n", o_cs_n, 1);
    chk("tmo cmd0", n0, 1);
    chk("tmo cmd8", n8, 0);
    chk("tmo dummy", dummy_cyc, DUMMY);
    chk("tmo cs low", cs_low_cyc, 48 + TMO);
    // Flag rises on the TMO-th edge after the edge closing the last bit.
    chk("tmo latency", err_cyc - c0_cyc, TMO + 1);

    // CMD8 echo wrong: error, no CMD55 ever shifted out.
    silent = 1'b0; cmd8_bad = 1'b1;
    start_run();
    wait_end("r7");
    chk("r7 error", o_error, 1);
    chk("r7 ready", o_ready, 0);
    chk("r7 cmd8", n8, 1);
    chk("r7 cmd55", n55, 0);
    chk("r7 zero bits", zeros8, 0);
    chk("r7 cs_n", o_cs_n, 1);

    // Card stays busy: retries exhausted.
    cmd8_bad = 1'b0; a41_busy = 1000;
    start_run();
    wait_end("retry");
    chk("retry error", o_error, 1);
    chk("retry ready", o_ready, 0);
    chk("retry cmd55", n55, RETRY);
    chk("retry acmd41", n41, RETRY);
    chk("retry wstart", ws_cnt, 0);

    // Reset while CMD8 bit 20 is on the wire.
    a41_busy = 1;
    start_run();
    begin
      int n = 0;
      while (n0 == 0 && n < 2000) begin @(negedge clk); #1; n++; end
    end
    chk("rst cmd0 seen", n0, 1);
    repeat (40) @(negedge clk);
    #1;
    chk("rst bit20 mosi", o_mosi, 0);
    chk("rst bit20 cs_n", o_cs_n, 0);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rst mid mosi", o_mosi, 1);
    chk("rst mid cs_n", o_cs_n, 1);
    chk("rst mid busy", o_busy, 0);
    rst = 1'b0;

    // Full successful init after the reset.
    start_run();
    wait_end("init");
    chk("init ready", o_ready, 1);
    chk("init error", o_error, 0);
    chk("init busy", o_busy, 0);
    chk("init dummy", dummy_cyc, DUMMY);
    chk("init cmd0", n0, 1);
    chk("init cmd8", n8, 1);
    chk("init cmd55", n55, 2);
    chk("init acmd41", n41, 2);
    chk("init wstart", ws_cnt, 1);
    chk("init wstart lat", ws_cyc - c41_cyc, 12);

    // Writer owns the bus; extra start ignored.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      wmosi = tv[i].wm;
      start = tv[i].st;
      #1;
      chk($sformatf("done[%0d] mosi", i), o_mosi, tv[i].exp_mosi);
      chk($sformatf("done[%0d] cs_n", i), o_cs_n, tv[i].exp_cs_n);
      chk($sformatf("done[%0d] ready", i), o_ready, tv[i].exp_ready);
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("done wstart count", ws_cnt, 1);
    chk("done busy", o_busy, 0);
    chk("done error", o_error, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/sd_init_sequencer.md
SD_INIT_SEQUENCER -- requirements
Module: sd_init_sequencer

Interface
REQ-001 SHALL have parameter DUMMY_CLKS, default 80: MOSI-high, CS-high clocks sent before CMD0.
REQ-002 SHALL have parameter RESP_TIMEOUT, default 64: clocks allowed after a command's last bit for the response start bit.
REQ-003 SHALL have parameter RETRY_MAX, default 255: maximum CMD55/ACMD41 pairs sent before error.
REQ-004 SHALL have port i_s_clk  in  1  SPI bit clock; all logic on rising edge.
REQ-005 SHALL have port i_reset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_start  in  1  one-cycle request to begin initialisation.
REQ-007 SHALL have port MISO  in  1  card serial data out.
REQ-008 SHALL have port o_mosi  out  1  muxed serial data to card.
REQ-009 SHALL have port o_cs_n  out  1  card chip select, active-low.
REQ-010 SHALL have port i_writer_mosi  in  1  SD writer serial data, forwarded after init.
REQ-011 SHALL have port o_writer_start  out  1  one-cycle start pulse to the SD writer.
REQ-012 SHALL have port o_busy  out  1  high from accepted i_start until sDone or sError.
REQ-013 SHALL have port o_ready  out  1  card initialised; bus owned by writer.
REQ-014 SHALL have port o_error  out  1  init failed (bad response, timeout, or retries exhausted).

Function
REQ-015 SHALL implement states sIdle, sDummy, sSendCmd, sWaitResp, sRecv, sCheck, sGap, sDone, sError.
REQ-016 SHALL leave sIdle or sError on i_start, entering sDummy and clearing o_error; i_start in any other state SHALL be ignored.
REQ-017 sDummy SHALL last exactly DUMMY_CLKS cycles with o_mosi=1, o_cs_n=1, then enter sSendCmd with CMD0.
REQ-018 sSendCmd SHALL shift the 48-bit command MSB first, one bit per clock, o_cs_n=0, 48 cycles exactly.
REQ-019 Commands SHALL be CMD0=48'h40_0000_0000_95, CMD8=48'h48_0000_01AA_87, CMD55=48'h77_0000_0000_65, ACMD41=48'h69_4000_0000_77.
REQ-020 sWaitResp SHALL hold o_mosi=1 and sample MISO each clock; first MISO=0 enters sRecv; RESP_TIMEOUT clocks without it enters sError.
REQ-021 sRecv SHALL capture 8 bits (R1, start bit included as bit 7) for all commands, 40 bits (R1 + 32-bit R7) for CMD8.
REQ-022 sCheck (one cycle): CMD0 needs R1=8'h01; CMD8 needs R1=8'h01 and R7[11:0]=12'h1AA; CMD55 needs R1 in {8'h00,8'h01}; any mismatch enters sError.
REQ-023 ACMD41 R1=8'h00 SHALL enter sDone; R1=8'h01 SHALL increment the retry counter and reissue CMD55, or enter sError if count reaches RETRY_MAX; other values enter sError.
REQ-024 sGap SHALL insert 8 clocks of o_mosi=1, o_cs_n=0 between a passed check and the next command.
REQ-025 Entering sDone SHALL pulse o_writer_start for exactly one cycle and set o_ready; in sDone o_mosi=i_writer_mosi and o_cs_n=0 combinationally.
REQ-026 sError SHALL drive o_mosi=1, o_cs_n=1, o_error=1.
REQ-027 Bit, timeout, gap and dummy counters SHALL be sized to hold their parameter values without wrap; retry counter 8 bits.

Reset
REQ-028 On i_reset, including mid-command, SHALL go to sIdle immediately, clear all counters and shift registers.
REQ-029 Reset values: o_mosi=1, o_cs_n=1, o_writer_start=0, o_busy=0, o_ready=0, o_error=0.

Structure
REQ-030 Shared package sd_pkg SHALL hold the four command constants, R1/R7 expected values and state encoding.
REQ-031 SHALL instantiate one sub-module, sd_cmd_shifter: 48-bit load-and-shift-out register with busy flag.

Verification
REQ-032 Card model returns 01,01+000001AA,01,01 then 00 on ACMD41 -> o_ready=1 and one o_writer_start pulse after the second ACMD41; o_error=0.
REQ-033 Card never drives MISO low after CMD0 -> o_error=1 exactly RESP_TIMEOUT clocks after CMD0's last bit; o_cs_n=1.
REQ-034 CMD8 returns R7[11:0]=12'h0AA -> sError, no CMD55 bits on o_mosi.
REQ-035 ACMD41 always returns 01, RETRY_MAX=3 -> exactly 3 CMD55/ACMD41 pairs, then o_error=1.
REQ-036 i_reset asserted at bit 20 of CMD8 -> next cycle o_mosi=1, o_cs_n=1, o_busy=0; new i_start repeats full 80-clock dummy phase.
REQ-037 In sDone, toggle i_writer_mosi 1,0,1 -> o_mosi follows same cycle; extra i_start produces no second o_writer_start.
